rom_cache_2way: RTL and testbench

ROM_CACHE_2WAY -- requirements
Module: rom_cache_2way

---
 rtl/rom_cache_2way.sv | 187 ++++++++++++++++++
 tb/tb_rom_cache_2way.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_cache_2way.sv
// Two-way set-associative read cache in front of a slow backing ROM.
// Valid bits and LRU bits are cleared by a one-set-per-cycle sweep after reset and on flush.
module rom_cache_2way #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              cache_req,
   input  logic [ADDR_W-1:0] cache_addr,
   output logic              cache_valid,
   output logic [DATA_W-1:0] cache_data,
   output logic              busy,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              rom_valid
);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int SETS  = 1 << IDX_W;

   typedef enum logic [1:0] {SWEEP, IDLE, LOOKUP, FILL} state_t;

   state_t            state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              req_prev;
   logic              flush_pend;
   logic              victim_q;

   // Each tag entry is {valid, tag}.
   logic [TAG_W:0]    tag_ram  [2][SETS];
   logic [DATA_W-1:0] data_ram [2][SETS];
   logic              lru_ram  [SETS];
   logic [TAG_W:0]    tag_q    [2];
   logic [DATA_W-1:0] data_q   [2];
   logic              lru_q;

   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [TAG_W-1:0]  tag;
   logic              accept;
   logic              hit0;
   logic              hit1;
   logic              hit;
   logic              hit_way;
   logic              victim;
   logic              go_sweep;
   logic [1:0]        tag_we;
   logic [1:0]        data_we;
   logic [TAG_W:0]    tag_wdata;
   logic              lru_we;
   logic              lru_wdata;

   assign idx      = addr_q[IDX_W-1:0];
   assign tag      = addr_q[ADDR_W-1:IDX_W];
   assign accept   = (state == IDLE) && !flush && cache_req && !req_prev;
   assign hit0     = tag_q[0][TAG_W] && (tag_q[0][TAG_W-1:0] == tag);
   assign hit1     = tag_q[1][TAG_W] && (tag_q[1][TAG_W-1:0] == tag);
   assign hit      = hit0 || hit1;
   assign hit_way  = !hit0;
   assign victim   = !tag_q[0][TAG_W] ? 1'b0 :
                     !tag_q[1][TAG_W] ? 1'b1 : lru_q;
   assign go_sweep = flush || flush_pend;
   assign busy     = (state != IDLE);

   // Write enables follow the registered state, so an async reset mid-fill blocks the line write.
   always_comb begin
      tag_we    = '0;
      data_we   = '0;
      lru_we    = 1'b0;
      lru_wdata = 1'b0;
      tag_wdata = {1'b1, tag};
      wr_idx    = idx;
      if (state == SWEEP) begin
         tag_we    = '1;
         lru_we    = 1'b1;
         tag_wdata = '0;
         wr_idx    = sweep_cnt;
      end else if (state == LOOKUP && hit) begin
         lru_we    = 1'b1;
         lru_wdata = !hit_way;
      end else if (state == FILL && rom_valid) begin
         tag_we[victim_q]  = 1'b1;
         data_we[victim_q] = 1'b1;
         lru_we            = 1'b1;
         lru_wdata         = !victim_q;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned w = 0; w < 2; w++) begin
         if (tag_we[w])
            tag_ram[w][wr_idx] <= tag_wdata;
         if (data_we[w])
            data_ram[w][wr_idx] <= rom_data;
         if (state == IDLE) begin
            tag_q[w]  <= tag_ram[w][cache_addr[IDX_W-1:0]];
            data_q[w] <= data_ram[w][cache_addr[IDX_W-1:0]];
         end
      end
      if (lru_we)
         lru_ram[wr_idx] <= lru_wdata;
      if (state == IDLE)
         lru_q <= lru_ram[cache_addr[IDX_W-1:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SWEEP;
         sweep_cnt   <= '0;
         cache_valid <= 1'b0;
         cache_data  <= '0;
         rom_req     <= 1'b0;
         rom_addr    <= '0;
         flush_pend  <= 1'b0;
         req_prev    <= 1'b0;
         addr_q      <= '0;
         victim_q    <= 1'b0;
      end else begin
         req_prev    <= cache_req;
         cache_valid <= 1'b0;
         if (flush && (state == LOOKUP || state == FILL))
            flush_pend <= 1'b1;
         case (state)
            SWEEP: begin
               if (flush) begin
                  sweep_cnt <= '0;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
                  if (sweep_cnt == '1)
                     state <= IDLE;
               end
            end
            IDLE: begin
               if (flush) begin
                  state     <= SWEEP;
                  sweep_cnt <= '0;
               end else if (accept) begin
                  addr_q <= cache_addr;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (cache_req) begin
                     cache_valid <= 1'b1;
                     cache_data  <= hit0 ? data_q[0] : data_q[1];
                  end
                  if (go_sweep) begin
                     state      <= SWEEP;
                     sweep_cnt  <= '0;
                     flush_pend <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  victim_q <= victim;
                  rom_req  <= 1'b1;
                  rom_addr <= addr_q;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (rom_valid) begin
                  rom_req <= 1'b0;
                  if (cache_req) begin
                     cache_valid <= 1'b1;
                     cache_data  <= rom_data;
                  end
                  if (go_sweep) begin
                     state      <= SWEEP;
                     sweep_cnt  <= '0;
                     flush_pend <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= SWEEP;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_cache_2way.sv
// Directed bench for rom_cache_2way: table of read transactions plus flush/reset/drop sequences.
module tb_rom_cache_2way;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 10;
   localparam int SETS   = 1 << IDX_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              cache_req;
   logic [ADDR_W-1:0] cache_addr;
   logic              cache_valid;
   logic [DATA_W-1:0] cache_data;
   logic              busy;
   logic              rom_req;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              rom_valid;

   always #5 clk = ~clk;

   rom_cache_2way #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .cache_req(cache_req), .cache_addr(cache_addr),
      .cache_valid(cache_valid), .cache_data(cache_data), .busy(busy),
      .rom_req(rom_req), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_valid(rom_valid)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One read transaction with a ROM responder answering dly cycles after rom_req rises.
   task automatic run_req(input logic [ADDR_W-1:0] a, input int dly, input logic [DATA_W-1:0] word,
                          input int drop_cyc, input int flush_cyc,
                          output int lat, output bit used_rom, output bit addr_ok,
                          output logic [DATA_W-1:0] rdata, output bit seen);
      int rom_cnt;
      bit rv_sent;
      @(negedge clk);
      cache_addr = a;
      cache_req  = 1'b1;
      lat = -1; used_rom = 0; addr_ok = 0; rdata = '0; seen = 0;
      rom_cnt = -1; rv_sent = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         rom_valid = 1'b0;
         flush     = 1'b0;
         if (cache_valid) begin
            seen = 1; lat = cyc; rdata = cache_data;
            cache_req = 1'b0;
            break;
         end
         if (!cache_req && !busy) break;
         if (rom_req && !rv_sent) begin
            if (rom_cnt < 0) begin
               rom_cnt  = 0;
               used_rom = 1;
               addr_ok  = (rom_addr == a);
            end
            if (rom_cnt == dly) begin
               rom_valid = 1'b1;
               rom_data  = word;
               rv_sent   = 1;
            end
            rom_cnt++;
         end
         if (cyc == flush_cyc) flush = 1'b1;
         if (cyc == drop_cyc) cache_req = 1'b0;
      end
      cache_req = 1'b0;
   endtask

   // Counts consecutive busy cycles starting with the current sample; optional flush pulse mid-way.
   task automatic count_busy(input int flush_at, output int n, output bit sv);
      n = 0; sv = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!busy) break;
         n++;
         if (n == flush_at) flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         rom_valid = 1'b0;
         if (cache_valid) sv = 1;
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                dly;
      logic [DATA_W-1:0] word;
      bit                miss;
      logic [DATA_W-1:0] exp_data;
   } vec_t;

   vec_t vecs [22];

   task automatic check_txn(input string tag, input bit miss, input int dly,
                            input logic [DATA_W-1:0] exp_data, input int lat, input bit used_rom,
                            input bit addr_ok, input logic [DATA_W-1:0] rdata, input bit seen);
      chk({tag, "_valid"}, seen, 1);
      chk({tag, "_latency"}, lat, miss ? dly + 3 : 2);
      chk({tag, "_data"}, rdata, exp_data);
      chk({tag, "_rom_used"}, used_rom, miss);
      if (miss) chk({tag, "_rom_addr"}, addr_ok, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, n;
      bit used_rom, addr_ok, seen, sv;
      logic [DATA_W-1:0] rdata;

      // set 0x010 sees tags 0,1,2 to exercise LRU replacement; set 0x3FF is the top set
      vecs[0]  = '{20'h12345, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF};
      vecs[1]  = '{20'h12345, 0, 32'h0,        0, 32'hDEADBEEF};
      vecs[2]  = '{20'h00010, 1, 32'hA0000010, 1, 32'hA0000010};
      vecs[3]  = '{20'h00410, 2, 32'hA0000410, 1, 32'hA0000410};
      vecs[4]  = '{20'h00010, 0, 32'h0,        0, 32'hA0000010};
      vecs[5]  = '{20'h00810, 0, 32'hA0000810, 1, 32'hA0000810};
      vecs[6]  = '{20'h00010, 0, 32'h0,        0, 32'hA0000010};
      vecs[7]  = '{20'h00410, 3, 32'hB0000410, 1, 32'hB0000410};
      vecs[8]  = '{20'h00010, 0, 32'h0,        0, 32'hA0000010};
      vecs[9]  = '{20'h00810, 0, 32'hC0000810, 1, 32'hC0000810};
      vecs[10] = '{20'h00010, 0, 32'h0,        0, 32'hA0000010};
      vecs[11] = '{20'h00810, 0, 32'h0,        0, 32'hC0000810};
      vecs[12] = '{20'h00410, 2, 32'hD0000410, 1, 32'hD0000410};
      vecs[13] = '{20'h00010, 1, 32'hE0000010, 1, 32'hE0000010};
      vecs[14] = '{20'h00410, 0, 32'h0,        0, 32'hD0000410};
      vecs[15] = '{20'hFFFFF, 4, 32'h0BADF00D, 1, 32'h0BADF00D};
      vecs[16] = '{20'hFFFFF, 0, 32'h0,        0, 32'h0BADF00D};
      vecs[17] = '{20'h003FF, 1, 32'h12340000, 1, 32'h12340000};
      vecs[18] = '{20'hFFFFF, 0, 32'h0,        0, 32'h0BADF00D};
      vecs[19] = '{20'h003FF, 0, 32'h0,        0, 32'h12340000};
      vecs[20] = '{20'h12345, 0, 32'h0,        0, 32'hDEADBEEF};
      vecs[21] = '{20'h00000, 2, 32'h55AA55AA, 1, 32'h55AA55AA};

      reset = 1'b1; flush = 1'b0; cache_req = 1'b0; cache_addr = '0;
      rom_data = '0; rom_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cache_valid", cache_valid, 0);
      chk("rst_rom_req", rom_req, 0);
      chk("rst_busy", busy, 1);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_cache_data", cache_data, 0);

      reset = 1'b0;
      count_busy(0, n, sv);
      chk("init_sweep_len", n, SETS);
      chk("init_sweep_no_valid", sv, 0);

      // rom_valid while idle must be ignored
      rom_valid = 1'b1; rom_data = 32'h11111111;
      @(negedge clk);
      rom_valid = 1'b0;
      chk("idle_romvalid_no_valid", cache_valid, 0);
      chk("idle_romvalid_not_busy", busy, 0);

      for (int i = 0; i < 22; i++) begin
         run_req(vecs[i].addr, vecs[i].dly, vecs[i].word, -1, -1, lat, used_rom, addr_ok, rdata, seen);
         check_txn($sformatf("vec%0d", i), vecs[i].miss, vecs[i].dly, vecs[i].exp_data,
                   lat, used_rom, addr_ok, rdata, seen);
      end

      // flush pulse during a fill: transaction still completes, then full sweep
      run_req(20'h00020, 4, 32'h20202020, -1, 3, lat, used_rom, addr_ok, rdata, seen);
      check_txn("flushfill", 1, 4, 32'h20202020, lat, used_rom, addr_ok, rdata, seen);
      count_busy(0, n, sv);
      chk("flushfill_sweep_len", n, SETS);
      chk("flushfill_sweep_no_valid", sv, 0);
      run_req(20'h00020, 1, 32'h20202021, -1, -1, lat, used_rom, addr_ok, rdata, seen);
      check_txn("after_flush_miss", 1, 1, 32'h20202021, lat, used_rom, addr_ok, rdata, seen);

      // flush and request edge together in IDLE; flush again mid-sweep restarts the counter
      @(negedge clk);
      flush = 1'b1; cache_req = 1'b1; cache_addr = 20'h12345;
      @(negedge clk);
      flush = 1'b0;
      count_busy(500, n, sv);
      chk("restart_sweep_len", n, 500 + SETS);
      chk("restart_sweep_no_valid", sv, 0);
      sv = 0;
      repeat (5) begin
         @(negedge clk);
         if (cache_valid || rom_req || busy) sv = 1;
      end
      chk("held_req_not_accepted", sv, 0);
      cache_req = 1'b0;
      run_req(20'h12345, 2, 32'hFEEDFACE, -1, -1, lat, used_rom, addr_ok, rdata, seen);
      check_txn("post_flush_12345", 1, 2, 32'hFEEDFACE, lat, used_rom, addr_ok, rdata, seen);

      // request dropped mid-fill: no pulse, but the line is still written
      run_req(20'h00040, 3, 32'h40404040, 3, -1, lat, used_rom, addr_ok, rdata, seen);
      chk("drop_no_valid", seen, 0);
      chk("drop_rom_used", used_rom, 1);
      chk("drop_idle_after", busy, 0);
      run_req(20'h00040, 0, 32'h0, -1, -1, lat, used_rom, addr_ok, rdata, seen);
      check_txn("drop_then_hit", 0, 0, 32'h40404040, lat, used_rom, addr_ok, rdata, seen);

      // reset asserted during a fill
      @(negedge clk);
      cache_addr = 20'h00030; cache_req = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rom_req) break;
         n++;
      end
      chk("prereset_rom_req", rom_req, 1);
      reset = 1'b1;
      #1;
      chk("reset_async_rom_req", rom_req, 0);
      chk("reset_async_busy", busy, 1);
      chk("reset_async_rom_addr", rom_addr, 0);
      cache_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rom_valid = 1'b1; rom_data = 32'h99999999;
      count_busy(0, n, sv);
      chk("postreset_sweep_len", n, SETS);
      chk("postreset_stale_romvalid", sv, 0);
      run_req(20'h00030, 1, 32'h30303030, -1, -1, lat, used_rom, addr_ok, rdata, seen);
      check_txn("postreset_miss", 1, 1, 32'h30303030, lat, used_rom, addr_ok, rdata, seen);
      run_req(20'h12345, 0, 32'h0BB0BB0B, -1, -1, lat, used_rom, addr_ok, rdata, seen);
      check_txn("postreset_12345_miss", 1, 0, 32'h0BB0BB0B, lat, used_rom, addr_ok, rdata, seen);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
